// File: rtl/bcd_chain_if.sv
// Command handshake bundle for bcd_chain_ctrl: valid/ready plus opcode and payload.
interface bcd_chain_if #(
  parameter int DIGITS = 4
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [4*DIGITS-1:0]   cmd_data;

  modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);
endinterface

// File: rtl/bcd_chain_ctrl.sv
// Sequencer for a cascaded chain of BCD decade counters with load, clear and match/wrap flags.
// Optional down-counting is enabled by defining BCD_CHAIN_DOWN_EN (adds the cnt_down port).
module bcd_chain_ctrl #(
  parameter int DIGITS      = 4,
  parameter bit ONESHOT_DEF = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  bcd_chain_if.slave          cmd,
  input  logic [4*DIGITS-1:0] match_val,
  input  logic                tick_in,
`ifdef BCD_CHAIN_DOWN_EN
  input  logic                cnt_down,
`endif
  output logic [4*DIGITS-1:0] cnt_bcd,
  output logic                carry_out,
  output logic                match_pulse,
  output logic                running,
  output logic                done,
  output logic                load_err
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_CLEAR = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_STOP  = 2'd1;
  localparam logic [1:0] OP_LOAD  = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  logic [2:0]       state;
  logic [W-1:0]     cnt;
  logic [W-1:0]     load_buf;
  logic [IDX_W-1:0] load_idx;
  logic             oneshot;
  logic             clr_to_run;
  logic             accept;
  logic             step_down;
  logic [W-1:0]     cnt_nxt;
  logic             wrap;
  logic             hit;

  function automatic logic [W-1:0] bcd_up(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (c) begin
        if (v[4*k +: 4] >= 4'd9) begin
          r[4*k +: 4] = 4'd0;
        end else begin
          r[4*k +: 4] = v[4*k +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_down(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (b) begin
        if (v[4*k +: 4] == 4'd0) begin
          r[4*k +: 4] = 4'd9;
        end else begin
          r[4*k +: 4] = v[4*k +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic all_nines(input logic [W-1:0] v);
    logic a;
    a = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (v[4*k +: 4] != 4'd9) a = 1'b0;
    end
    return a;
  endfunction

  always_comb begin
`ifdef BCD_CHAIN_DOWN_EN
    step_down = cnt_down;
`else
    step_down = 1'b0;
`endif
    cnt_nxt = step_down ? bcd_down(cnt) : bcd_up(cnt);
    wrap    = step_down ? (cnt == '0) : all_nines(cnt);
    hit     = (cnt_nxt == match_val);
  end

  assign cmd.cmd_ready = (state == S_IDLE) || (state == S_RUN) || (state == S_DONE);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign cnt_bcd       = cnt;
  assign running       = (state == S_RUN);
  assign done          = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      load_buf    <= '0;
      load_idx    <= '0;
      oneshot     <= ONESHOT_DEF;
      clr_to_run  <= 1'b0;
      carry_out   <= 1'b0;
      match_pulse <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      carry_out   <= 1'b0;
      match_pulse <= 1'b0;
      case (state)
        S_IDLE, S_RUN, S_DONE: begin
          // A tick in RUN is counted even when a command is accepted in the same cycle.
          if (state == S_RUN && tick_in) begin
            cnt         <= cnt_nxt;
            carry_out   <= wrap;
            match_pulse <= hit;
            if (hit && oneshot) state <= S_DONE;
          end
          if (accept) begin
            case (cmd.cmd_op)
              OP_START: begin
                if (state != S_RUN) state <= S_RUN;
                if (state == S_IDLE) oneshot <= cmd.cmd_data[0];
              end
              OP_STOP: state <= S_IDLE;
              OP_LOAD: begin
                state    <= S_LOAD;
                load_idx <= '0;
                load_buf <= cmd.cmd_data;
              end
              OP_CLEAR: begin
                state      <= S_CLEAR;
                clr_to_run <= (state == S_RUN);
                load_err   <= 1'b0;
              end
            endcase
          end
        end
        S_LOAD: begin
          // One digit per cycle, lowest first; out-of-range digits become 0.
          for (int k = 0; k < DIGITS; k++) begin
            if (load_idx == IDX_W'(k)) begin
              cnt[4*k +: 4] <= (load_buf[3:0] > 4'd9) ? 4'd0 : load_buf[3:0];
            end
          end
          if (load_buf[3:0] > 4'd9) load_err <= 1'b1;
          load_buf <= load_buf >> 4;
          if (load_idx == IDX_W'(DIGITS - 1)) begin
            state <= S_IDLE;
          end else begin
            load_idx <= load_idx + IDX_W'(1);
          end
        end
        S_CLEAR: begin
          cnt   <= '0;
          state <= clr_to_run ? S_RUN : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
